// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator: one registered log-stage per shift-amount bit, valid/ready on both sides.
// Define SHIFT_PIPE_CARRY_EN to add out_carry (last bit shifted or rotated out, pipelined with the data).
module shift_pipe #(
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
`ifdef SHIFT_PIPE_CARRY_EN
    ,
    output logic             out_carry
`endif
);

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [AW-1:0]    amt;
        logic [2:0]       op;
        logic             sign;
`ifdef SHIFT_PIPE_CARRY_EN
        logic             carry;
`endif
    } stage_t;

    // Shift by a fixed k; SRA fills from the sign carried with the op, not from d's own MSB.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d, input int unsigned k,
                                                  input logic [2:0] op, input logic sign);
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> k) : '0;
        case (op_e'(op))
            OP_SLL:  shift_by = d << k;
            OP_SRL:  shift_by = d >> k;
            OP_SRA:  shift_by = (d >> k) | fill;
            OP_ROL:  shift_by = (d << k) | (d >> (WIDTH - k));
            OP_ROR:  shift_by = (d >> k) | (d << (WIDTH - k));
            default: shift_by = d;
        endcase
    endfunction

    // Last bit to leave d when shifted by k; for rotations it is the bit that wrapped around.
    function automatic logic carry_of(input logic [WIDTH-1:0] d, input int unsigned k,
                                      input logic [2:0] op, input logic [WIDTH-1:0] res);
        logic [WIDTH-1:0] t;
        t        = '0;
        carry_of = 1'b0;
        case (op_e'(op))
            OP_SLL: begin
                t        = d >> (WIDTH - k);
                carry_of = t[0];
            end
            OP_SRL, OP_SRA: begin
                t        = d >> (k - 1);
                carry_of = t[0];
            end
            OP_ROL:  carry_of = res[0];
            OP_ROR:  carry_of = res[WIDTH-1];
            default: carry_of = 1'b0;
        endcase
    endfunction

    stage_t head;
    stage_t stg_q [AW];
    logic   adv;

    assign adv      = ~stg_q[AW-1].valid | out_ready;
    assign in_ready = adv;

    // NOTE: combinational blocks assign every output a default first so no latch can be inferred.
    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.data  = in_data;
        head.amt   = in_amt;
        head.op    = in_op;
        head.sign  = in_data[WIDTH-1];
    end

    for (genvar i = 0; i < AW; i++) begin : g_stage
        localparam int unsigned    SH      = 1 << i;
        localparam logic [AW-1:0]  AMT_BIT = AW'(1 << i);

        stage_t           prev;
        logic [WIDTH-1:0] shifted;

        if (i == 0) begin : g_first
            assign prev = head;
        end else begin : g_next
            assign prev = stg_q[i-1];
        end

        assign shifted = shift_by(prev.data, SH, prev.op, prev.sign);

        // NOTE: sequential state uses non-blocking assignment so every stage samples the pre-edge value of its predecessor.
        // NOTE: payload fields are reset too, so out_data reads 0 after reset rather than stale contents.
        always_ff @(posedge clk) begin
            if (rst) begin
                stg_q[i] <= '0;
            end else if (adv) begin
                stg_q[i].valid <= prev.valid;
                // Bubbles move only the valid bit; payload keeps the last real operation.
                if (prev.valid) begin
                    stg_q[i].data <= prev.amt[i] ? shifted : prev.data;
                    stg_q[i].amt  <= prev.amt & ~AMT_BIT;
                    stg_q[i].op   <= prev.op;
                    stg_q[i].sign <= prev.sign;
`ifdef SHIFT_PIPE_CARRY_EN
                    stg_q[i].carry <= prev.amt[i] ? carry_of(prev.data, SH, prev.op, shifted)
                                                  : prev.carry;
`endif
                end
            end
        end
    end

    assign out_valid = stg_q[AW-1].valid;
    assign out_data  = stg_q[AW-1].data;
    assign out_zero  = out_valid & (out_data == '0);

`ifdef SHIFT_PIPE_CARRY_EN
    assign out_carry = stg_q[AW-1].carry;
`else
    // No carry path in this build; the carry field is absent from every stage.
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe (WIDTH=16): reset, latency, modes, throughput, stall/drain, zero flag, mid-flight reset.
// Checks out_carry as well when SHIFT_PIPE_CARRY_EN is defined.
module tb_shift_pipe;

    localparam int WIDTH = 16;
    localparam int AW    = 4;

    localparam logic [2:0] SLL  = 3'd0;
    localparam logic [2:0] SRL  = 3'd1;
    localparam logic [2:0] SRA  = 3'd2;
    localparam logic [2:0] ROL  = 3'd3;
    localparam logic [2:0] ROR  = 3'd4;
    localparam logic [2:0] PASS = 3'd6;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
`ifdef SHIFT_PIPE_CARRY_EN
    logic             out_carry;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
`ifdef SHIFT_PIPE_CARRY_EN
        ,
        .out_carry (out_carry)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_carry(input string tag, input logic exp);
`ifdef SHIFT_PIPE_CARRY_EN
        check({tag, ".carry"}, 32'(out_carry), 32'(exp));
`else
        if (exp === 1'bx) $display("carry %s unused", tag);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] d,
                         input logic [AW-1:0] n);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_amt   = n;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, '0, '0);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] d, input logic c);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".zero"},  32'(out_zero),  32'(d == '0));
        check_carry(tag, c);
    endtask

    // One isolated op with out_ready=1: result shows after the 4th edge counting the acceptance edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] d,
                          input logic [AW-1:0] n, input logic [WIDTH-1:0] exp, input logic c);
        drive(1'b1, op, d, n);
        step();
        idle();
        repeat (AW - 2) step();
        check({tag, ".early"}, 32'(out_valid), 32'd0);
        step();
        check_result(tag, exp, c);
        step();
        check({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [WIDTH-1:0] stall_exp [4];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data",  32'(out_data),  32'd0);
        check("rst.zero",  32'(out_zero),  32'd0);
        check("rst.ready", 32'(in_ready),  32'd1);
        check_carry("rst", 1'b0);

        // Latency: SRA 0x8001 by 1
        drive(1'b1, SRA, 16'h8001, 4'd1);
        check("lat.in_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        check("lat.e1", 32'(out_valid), 32'd0);
        step();
        check("lat.e2", 32'(out_valid), 32'd0);
        step();
        check("lat.e3", 32'(out_valid), 32'd0);
        step();
        check_result("lat", 16'hC000, 1'b1);
        step();
        check("lat.drained", 32'(out_valid), 32'd0);

        // Modes and boundaries
        run_op("ror1",   ROR,  16'h0001, 4'd1,  16'h8000, 1'b1);
        run_op("rol1",   ROL,  16'h8000, 4'd1,  16'h0001, 1'b1);
        run_op("sll15",  SLL,  16'hFFFF, 4'd15, 16'h8000, 1'b1);
        run_op("srl15",  SRL,  16'hFFFF, 4'd15, 16'h0001, 1'b1);
        run_op("pass",   PASS, 16'h1234, 4'd7,  16'h1234, 1'b0);
        run_op("rol4",   ROL,  16'h1234, 4'd4,  16'h2341, 1'b1);
        run_op("sra_pos", SRA, 16'h7F00, 4'd8,  16'h007F, 1'b0);
        run_op("sra15",  SRA,  16'h8000, 4'd15, 16'hFFFF, 1'b0);
        run_op("sra0",   SRA,  16'h8001, 4'd0,  16'h8001, 1'b0);
        run_op("zero",   SRL,  16'h0001, 4'd1,  16'h0000, 1'b1);

        // Throughput: back-to-back SLL 0x0001 by 0..3
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, SLL, 16'h0001, AW'(i));
            step();
        end
        idle();
        check_result("tput0", 16'h0001, 1'b0);
        step();
        check_result("tput1", 16'h0002, 1'b0);
        step();
        check_result("tput2", 16'h0004, 1'b0);
        step();
        check_result("tput3", 16'h0008, 1'b0);
        step();
        check("tput.drained", 32'(out_valid), 32'd0);

        // Stall: fill with ROL 0x00F0 by 0..3, hold for 3 cycles, then drain while accepting one more
        stall_exp[0] = 16'h00F0;
        stall_exp[1] = 16'h01E0;
        stall_exp[2] = 16'h03C0;
        stall_exp[3] = 16'h0780;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ROL, 16'h00F0, AW'(i));
            step();
        end
        out_ready = 1'b0;
        drive(1'b1, PASS, 16'hAAAA, 4'd0);
        #1;
        check("stall.in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_result($sformatf("stall%0d", i), stall_exp[0], 1'b0);
            check($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'd0);
        end
        drive(1'b1, PASS, 16'hBEEF, 4'd5);
        out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        for (int i = 1; i < 4; i++) begin
            check_result($sformatf("drain%0d", i), stall_exp[i], 1'b0);
            step();
        end
        check_result("drain_new", 16'hBEEF, 1'b0);
        step();
        check("drain.empty", 32'(out_valid), 32'd0);

        // Reset mid-flight: two ops in the pipe are discarded
        drive(1'b1, SLL, 16'h0003, 4'd1);
        step();
        drive(1'b1, SRL, 16'hF000, 4'd2);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("mrst%0d.valid", i), 32'(out_valid), 32'd0);
            check($sformatf("mrst%0d.ready", i), 32'(in_ready),  32'd1);
            check($sformatf("mrst%0d.data", i),  32'(out_data),  32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
